// File: rtl/cc_flag_unit.sv
// Condition-flag producer: computes or accepts N/Z/C/V, holds them in a
// pending/commit pair, and keeps a one-entry shadow copy for exceptions.
module cc_flag_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             kill,
   input  logic             set_flags,
   input  logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             a_msb,
   input  logic             b_msb,
   input  logic             carry_in,
   input  logic             flag_wr,
   input  logic [3:0]       flag_wdata,
   input  logic             save,
   input  logic             restore,
   output logic [3:0]       flag,
   output logic             flag_pending,
   output logic [3:0]       shadow_flag
);

   localparam logic [1:0] OP_LOGIC = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;

   logic [3:0] pend_p0;
   logic       vld_p0;
   logic [3:0] flag_p1;
   logic [3:0] shadow_q;

   logic [1:0] prev_cv;
   logic [3:0] calc_p0;
   logic       advance;
   logic [3:0] flag_next;

   // Logic ops keep the prior C and V; only add/sub produce a fresh overflow.
   function automatic logic [3:0] calc_flags(
      input logic [1:0]              op,
      input logic signed [WIDTH-1:0] res,
      input logic                    a,
      input logic                    b,
      input logic                    cin,
      input logic [1:0]              prev
   );
      logic n, z, c, v;
      n = (res < 0);
      z = (res == 0);
      c = cin;
      v = prev[0];
      case (op)
         OP_LOGIC: c = prev[1];
         OP_ADD:   v = (a == b) && (n != a);
         OP_SUB:   v = (a != b) && (n != a);
         default:  v = prev[0];
      endcase
      return {n, z, c, v};
   endfunction

   assign prev_cv   = vld_p0 ? pend_p0[1:0] : flag_p1[1:0];
   assign calc_p0   = calc_flags(alu_op, alu_res, a_msb, b_msb, carry_in, prev_cv);
   assign advance   = !stall && !kill && !restore;
   assign flag_next = (advance && vld_p0) ? pend_p0 : flag_p1;

   // Stage p0: pending entry; stage p1: committed flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_p0  <= 4'b0000;
         vld_p0   <= 1'b0;
         flag_p1  <= 4'b0000;
         shadow_q <= 4'b0000;
      end else begin
         if (restore) begin
            flag_p1 <= shadow_q;
            vld_p0  <= 1'b0;
         end else if (kill) begin
            vld_p0  <= 1'b0;
         end else if (!stall) begin
            flag_p1 <= flag_next;
            if (set_flags) begin
               pend_p0 <= calc_p0;
               vld_p0  <= 1'b1;
            end else if (flag_wr) begin
               pend_p0 <= flag_wdata;
               vld_p0  <= 1'b1;
            end else begin
               vld_p0  <= 1'b0;
            end
         end
         if (save && !restore) shadow_q <= flag_next;
      end
   end

   assign flag         = flag_p1;
   assign flag_pending = vld_p0;
   assign shadow_flag  = shadow_q;

endmodule

// File: tb/tb_cc_flag_unit.sv
// Directed bench for cc_flag_unit: per-cycle compare against a queue-based
// reference model plus literal expectations for the key scenarios.
module tb_cc_flag_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         stall, kill, set_flags, a_msb, b_msb, carry_in, flag_wr, save, restore;
   logic [1:0]   alu_op;
   logic [W-1:0] alu_res;
   logic [3:0]   flag_wdata;
   logic [3:0]   flag;
   logic         flag_pending;
   logic [3:0]   shadow_flag;

   int checks = 0;
   int errors = 0;

   cc_flag_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .kill(kill), .set_flags(set_flags),
      .alu_op(alu_op), .alu_res(alu_res), .a_msb(a_msb), .b_msb(b_msb),
      .carry_in(carry_in), .flag_wr(flag_wr), .flag_wdata(flag_wdata),
      .save(save), .restore(restore), .flag(flag), .flag_pending(flag_pending),
      .shadow_flag(shadow_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: committed flags, shadow, and a queue of in-flight updates.
   logic [3:0] m_flag = 4'b0000;
   logic [3:0] m_shadow = 4'b0000;
   logic [3:0] inflight[$];

   function automatic logic [3:0] model_flags(input logic [1:0] op, input logic [W-1:0] res,
                                              input logic a, input logic b, input logic cin,
                                              input logic [1:0] prev);
      logic n, z, c, v, b_eff;
      n = res[W-1];
      z = (res == '0);
      c = (op == 2'b00) ? prev[1] : cin;
      v = prev[0];
      if (op == 2'b01 || op == 2'b10) begin
         b_eff = (op == 2'b10) ? ~b : b;  // sign of the addend the adder really sees
         v = (a == b_eff) && (n != a);
      end
      return {n, z, c, v};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_flag = 4'b0000;
         m_shadow = 4'b0000;
         inflight.delete();
      end else if (restore) begin
         m_flag = m_shadow;
         inflight.delete();
      end else if (kill || stall) begin
         if (kill) inflight.delete();
         if (save) m_shadow = m_flag;
      end else begin
         logic [1:0] prev;
         logic [3:0] newf;
         prev = (inflight.size() != 0) ? inflight[0][1:0] : m_flag[1:0];
         newf = model_flags(alu_op, alu_res, a_msb, b_msb, carry_in, prev);
         if (inflight.size() != 0) m_flag = inflight.pop_front();
         if (set_flags) inflight.push_back(newf);
         else if (flag_wr) inflight.push_back(flag_wdata);
         if (save) m_shadow = m_flag;
      end
   end

   always @(negedge clk) begin
      chk("model_flag", flag, m_flag);
      chk("model_pending", {3'b000, flag_pending}, {3'b000, inflight.size() != 0});
      chk("model_shadow", shadow_flag, m_shadow);
   end

   task automatic idle();
      stall = 0; kill = 0; set_flags = 0; alu_op = 2'b00; alu_res = '0;
      a_msb = 0; b_msb = 0; carry_in = 0; flag_wr = 0; flag_wdata = 4'b0000;
      save = 0; restore = 0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic alu(input logic [1:0] op, input logic [W-1:0] res,
                      input logic a, input logic b, input logic cin);
      set_flags = 1; alu_op = op; alu_res = res; a_msb = a; b_msb = b; carry_in = cin;
   endtask

   task automatic wr(input logic [3:0] d);
      flag_wr = 1; flag_wdata = d;
   endtask

   initial begin
      idle();
      rst_n = 0;
      #1;
      chk("reset_flag", flag, 4'b0000);
      chk("reset_pending", {3'b000, flag_pending}, 4'b0000);
      chk("reset_shadow", shadow_flag, 4'b0000);
      #11 rst_n = 1;
      step();

      // Add overflow
      alu(2'b01, 32'h8000_0000, 0, 0, 0);
      step(); idle();
      chk("add_pending", {3'b000, flag_pending}, 4'b0001);
      chk("add_flag_hold", flag, 4'b0000);
      step();
      chk("add_flag", flag, 4'b1001);
      chk("add_pending_clear", {3'b000, flag_pending}, 4'b0000);

      // Sub equal then logic, back-to-back
      alu(2'b10, 32'h0, 1, 1, 1);
      step();
      alu(2'b00, 32'h5, 0, 0, 0);
      step(); idle();
      chk("sub_flag", flag, 4'b0110);
      chk("sub_pending", {3'b000, flag_pending}, 4'b0001);
      step();
      chk("logic_flag", flag, 4'b0010);

      // Stall
      wr(4'b0000); step(); idle(); step();
      chk("clear_flag", flag, 4'b0000);
      alu(2'b01, 32'h8000_0000, 0, 0, 0);
      step(); idle();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_flag", flag, 4'b0000);
         chk("stall_pending", {3'b000, flag_pending}, 4'b0001);
      end
      stall = 0;
      step();
      chk("unstall_flag", flag, 4'b1001);

      // Kill during pending, with a set_flags that must also be dropped
      wr(4'b0000); step(); idle(); step();
      alu(2'b01, 32'h8000_0000, 0, 0, 0);
      step();
      kill = 1; stall = 1; alu(2'b10, 32'h0, 1, 1, 1);
      step(); idle();
      chk("kill_flag", flag, 4'b0000);
      chk("kill_pending", {3'b000, flag_pending}, 4'b0000);
      step();
      chk("kill_flag_after", flag, 4'b0000);

      // Direct write collides with set_flags
      alu(2'b00, 32'h0, 0, 0, 0); wr(4'b1111);
      step(); idle(); step();
      chk("collision_flag", flag, 4'b0100);

      // Save while a commit is happening captures the committing value
      wr(4'b0011); step(); idle();
      save = 1; step(); idle();
      chk("save_commit_shadow", shadow_flag, 4'b0011);

      // Save / restore
      alu(2'b01, 32'h8000_0000, 0, 0, 0); step(); idle(); step();
      chk("pre_save_flag", flag, 4'b1001);
      save = 1; step(); idle();
      chk("save_shadow", shadow_flag, 4'b1001);
      alu(2'b10, 32'h0, 1, 1, 1); step(); idle(); step();
      chk("update_flag", flag, 4'b0110);
      restore = 1; stall = 1; alu(2'b01, 32'h0000_0001, 1, 1, 0);
      step(); idle();
      chk("restore_flag", flag, 4'b1001);
      chk("restore_pending", {3'b000, flag_pending}, 4'b0000);
      step();
      chk("restore_ignored_set", flag, 4'b1001);
      wr(4'b0110); step(); idle(); step();
      save = 1; restore = 1; step(); idle();
      chk("save_restore_shadow", shadow_flag, 4'b1001);
      chk("save_restore_flag", flag, 4'b1001);

      // Asynchronous reset mid-cycle with an entry in flight
      wr(4'b1111); step(); idle();
      alu(2'b00, 32'h0, 0, 0, 0);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("async_flag", flag, 4'b0000);
      chk("async_pending", {3'b000, flag_pending}, 4'b0000);
      chk("async_shadow", shadow_flag, 4'b0000);
      idle();
      step();
      rst_n = 1;
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
